// File: rtl/wb_pkg.sv
// Shared encodings for the writeback/load-align slice: result selects, load funct3 codes,
// FSM state encoding and small load-size helpers.
package wb_pkg;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;
  localparam logic [1:0] WB_TGT = 2'd3;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LD  = 3'd3;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;
  localparam logic [2:0] F3_LWU = 3'd6;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SPLIT = 1'b1
  } state_t;

  function automatic logic [3:0] load_bytes(input logic [2:0] f3);
    case (f3)
      F3_LB, F3_LBU: return 4'd1;
      F3_LH, F3_LHU: return 4'd2;
      F3_LW, F3_LWU: return 4'd4;
      F3_LD:         return 4'd8;
      default:       return 4'd1;
    endcase
  endfunction

  // ld/lwu only exist on a 64-bit datapath; code 7 is never a load.
  function automatic logic load_ok(input logic [2:0] f3, input logic xlen64);
    case (f3)
      F3_LD, F3_LWU: return xlen64;
      3'd7:          return 1'b0;
      default:       return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/load_extract.sv
// Combinational load extractor: shifts a two-word window down by the byte offset and
// sign/zero-extends the selected byte/half/word/dword to XLEN.
module load_extract
  import wb_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int OW   = $clog2(XLEN/8)
) (
  input  logic [2*XLEN-1:0] i_window,
  input  logic [OW-1:0]     i_offset,
  input  logic [2:0]        i_funct3,
  output logic [XLEN-1:0]   o_data
);

  logic [OW+2:0]   w_shamt;
  logic [XLEN-1:0] w_s;

  assign w_shamt = {i_offset, 3'b000};
  assign w_s     = XLEN'(i_window >> w_shamt);

  // size/sign select; ld/lwu validity for the datapath width is decided by the caller
  always_comb begin
    o_data = {XLEN{1'b0}};
    case (i_funct3)
      F3_LB:   o_data = XLEN'(signed'(w_s[7:0]));
      F3_LH:   o_data = XLEN'(signed'(w_s[15:0]));
      F3_LW:   o_data = XLEN'(signed'(w_s[31:0]));
      F3_LD:   o_data = w_s;
      F3_LBU:  o_data = XLEN'(w_s[7:0]);
      F3_LHU:  o_data = XLEN'(w_s[15:0]);
      F3_LWU:  o_data = XLEN'(w_s[31:0]);
      default: o_data = {XLEN{1'b0}};
    endcase
  end

endmodule

// File: rtl/wb_load_align_unit.sv
// Registered writeback stage: picks ALU/load/PC+4/target result and aligns loads, fetching a
// second beat through the split port when a load straddles a word boundary.
module wb_load_align_unit
  import wb_pkg::*;
#(
  parameter int XLEN          = 32,
  parameter int MISALIGNED_EN = 1,
  parameter int OW            = $clog2(XLEN/8)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      in_wb_sel,
  input  logic [2:0]      in_funct3,
  input  logic [OW-1:0]   in_offset,
  input  logic [4:0]      in_rd,
  input  logic [XLEN-1:0] in_alu,
  input  logic [XLEN-1:0] in_pc4,
  input  logic [XLEN-1:0] in_target,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            split_req,
  input  logic            split_rvalid,
  input  logic [XLEN-1:0] split_rdata,
  output logic            wb_valid,
  output logic            wb_we,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            misalign_exc
);

  localparam int   NB     = XLEN/8;
  localparam logic XLEN64 = (XLEN == 64);
  localparam logic MIS_EN = (MISALIGNED_EN != 0);

  state_t          r_state;
  logic            r_in_ready;
  logic            r_split_req;
  logic            r_wb_valid;
  logic            r_wb_we;
  logic [4:0]      r_wb_rd;
  logic [XLEN-1:0] r_wb_data;
  logic            r_misalign_exc;
  logic [XLEN-1:0] r_beat1;
  logic [4:0]      r_rd;
  logic [2:0]      r_funct3;
  logic [OW-1:0]   r_offset;

  logic              w_is_load;
  logic              w_load_ok;
  logic [4:0]        w_end;
  logic              w_straddle;
  logic [2*XLEN-1:0] w_window;
  logic [OW-1:0]     w_offset;
  logic [2:0]        w_funct3;
  logic [XLEN-1:0]   w_ext;
  logic [XLEN-1:0]   w_result;
  logic              w_result_ok;

  assign w_is_load  = (in_wb_sel == WB_MEM);
  assign w_load_ok  = load_ok(in_funct3, XLEN64);
  assign w_end      = 5'(in_offset) + {1'b0, load_bytes(in_funct3)};
  assign w_straddle = w_is_load && w_load_ok && (w_end > 5'(NB));

  // In SPLIT the extractor sees the latched first beat under the incoming second beat.
  assign w_window = (r_state == ST_SPLIT) ? {split_rdata, r_beat1} : {{XLEN{1'b0}}, mem_rdata};
  assign w_offset = (r_state == ST_SPLIT) ? r_offset : in_offset;
  assign w_funct3 = (r_state == ST_SPLIT) ? r_funct3 : in_funct3;

  load_extract #(.XLEN(XLEN), .OW(OW)) u_extract (
    .i_window (w_window),
    .i_offset (w_offset),
    .i_funct3 (w_funct3),
    .o_data   (w_ext)
  );

  // single-beat result mux
  always_comb begin
    w_result    = {XLEN{1'b0}};
    w_result_ok = 1'b1;
    case (in_wb_sel)
      WB_ALU: w_result = in_alu;
      WB_MEM: begin
        w_result    = w_load_ok ? w_ext : {XLEN{1'b0}};
        w_result_ok = w_load_ok;
      end
      WB_PC4: w_result = in_pc4;
      WB_TGT: w_result = in_target;
      default: begin
        w_result    = {XLEN{1'b0}};
        w_result_ok = 1'b0;
      end
    endcase
  end

  // FSM and all registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_in_ready     <= 1'b0;
      r_split_req    <= 1'b0;
      r_wb_valid     <= 1'b0;
      r_wb_we        <= 1'b0;
      r_wb_rd        <= 5'd0;
      r_wb_data      <= {XLEN{1'b0}};
      r_misalign_exc <= 1'b0;
      r_beat1        <= {XLEN{1'b0}};
      r_rd           <= 5'd0;
      r_funct3       <= 3'd0;
      r_offset       <= {OW{1'b0}};
    end else begin
      r_wb_valid     <= 1'b0;
      r_wb_we        <= 1'b0;
      r_misalign_exc <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_in_ready  <= 1'b1;
          r_split_req <= 1'b0;
          if (in_valid && r_in_ready) begin
            if (w_straddle && MIS_EN) begin
              r_state     <= ST_SPLIT;
              r_in_ready  <= 1'b0;
              r_split_req <= 1'b1;
              r_beat1     <= mem_rdata;
              r_rd        <= in_rd;
              r_funct3    <= in_funct3;
              r_offset    <= in_offset;
            end else if (w_straddle) begin
              r_wb_valid     <= 1'b1;
              r_wb_rd        <= in_rd;
              r_wb_data      <= {XLEN{1'b0}};
              r_misalign_exc <= 1'b1;
            end else begin
              r_wb_valid <= 1'b1;
              r_wb_rd    <= in_rd;
              r_wb_data  <= w_result;
              r_wb_we    <= w_result_ok && (in_rd != 5'd0);
            end
          end
        end
        ST_SPLIT: begin
          if (split_rvalid) begin
            r_state     <= ST_IDLE;
            r_in_ready  <= 1'b1;
            r_split_req <= 1'b0;
            r_wb_valid  <= 1'b1;
            r_wb_rd     <= r_rd;
            r_wb_data   <= w_ext;
            r_wb_we     <= (r_rd != 5'd0);
          end else begin
            r_in_ready  <= 1'b0;
            r_split_req <= 1'b1;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_in_ready  <= 1'b0;
          r_split_req <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready     = r_in_ready;
  assign split_req    = r_split_req;
  assign wb_valid     = r_wb_valid;
  assign wb_we        = r_wb_we;
  assign wb_rd        = r_wb_rd;
  assign wb_data      = r_wb_data;
  assign misalign_exc = r_misalign_exc;

endmodule

// File: tb/tb_wb_load_align_unit.sv
// Directed bench: two XLEN=32 units (split enabled / disabled) share one stimulus bus,
// plus one XLEN=64 unit with its own bus.
module tb_wb_load_align_unit;
  import wb_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // shared 32-bit stimulus
  logic        in_valid, split_rvalid;
  logic [1:0]  in_wb_sel;
  logic [2:0]  in_funct3;
  logic [1:0]  in_offset;
  logic [4:0]  in_rd;
  logic [31:0] in_alu, in_pc4, in_target, mem_rdata, split_rdata;

  logic        a_in_ready, a_split_req, a_wb_valid, a_wb_we, a_misalign_exc;
  logic [4:0]  a_wb_rd;
  logic [31:0] a_wb_data;
  logic        b_in_ready, b_split_req, b_wb_valid, b_wb_we, b_misalign_exc;
  logic [4:0]  b_wb_rd;
  logic [31:0] b_wb_data;

  // 64-bit stimulus
  logic        c_in_valid, c_split_rvalid;
  logic [1:0]  c_in_wb_sel;
  logic [2:0]  c_in_funct3;
  logic [2:0]  c_in_offset;
  logic [4:0]  c_in_rd;
  logic [63:0] c_in_alu, c_in_pc4, c_in_target, c_mem_rdata, c_split_rdata;
  logic        c_in_ready, c_split_req, c_wb_valid, c_wb_we, c_misalign_exc;
  logic [4:0]  c_wb_rd;
  logic [63:0] c_wb_data;

  wb_load_align_unit #(.XLEN(32), .MISALIGNED_EN(1)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_wb_sel(in_wb_sel), .in_funct3(in_funct3), .in_offset(in_offset), .in_rd(in_rd),
    .in_alu(in_alu), .in_pc4(in_pc4), .in_target(in_target), .mem_rdata(mem_rdata),
    .split_req(a_split_req), .split_rvalid(split_rvalid), .split_rdata(split_rdata),
    .wb_valid(a_wb_valid), .wb_we(a_wb_we), .wb_rd(a_wb_rd), .wb_data(a_wb_data),
    .misalign_exc(a_misalign_exc)
  );

  wb_load_align_unit #(.XLEN(32), .MISALIGNED_EN(0)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_wb_sel(in_wb_sel), .in_funct3(in_funct3), .in_offset(in_offset), .in_rd(in_rd),
    .in_alu(in_alu), .in_pc4(in_pc4), .in_target(in_target), .mem_rdata(mem_rdata),
    .split_req(b_split_req), .split_rvalid(split_rvalid), .split_rdata(split_rdata),
    .wb_valid(b_wb_valid), .wb_we(b_wb_we), .wb_rd(b_wb_rd), .wb_data(b_wb_data),
    .misalign_exc(b_misalign_exc)
  );

  wb_load_align_unit #(.XLEN(64), .MISALIGNED_EN(1)) dut_c (
    .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .in_wb_sel(c_in_wb_sel), .in_funct3(c_in_funct3), .in_offset(c_in_offset), .in_rd(c_in_rd),
    .in_alu(c_in_alu), .in_pc4(c_in_pc4), .in_target(c_in_target), .mem_rdata(c_mem_rdata),
    .split_req(c_split_req), .split_rvalid(c_split_rvalid), .split_rdata(c_split_rdata),
    .wb_valid(c_wb_valid), .wb_we(c_wb_we), .wb_rd(c_wb_rd), .wb_data(c_wb_data),
    .misalign_exc(c_misalign_exc)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] sel, input logic [2:0] f3, input logic [1:0] off,
                       input logic [4:0] rd, input logic [31:0] mem);
    in_valid  = 1'b1;
    in_wb_sel = sel;
    in_funct3 = f3;
    in_offset = off;
    in_rd     = rd;
    mem_rdata = mem;
  endtask

  task automatic drive64(input logic [2:0] f3, input logic [2:0] off, input logic [4:0] rd,
                         input logic [63:0] mem);
    c_in_valid  = 1'b1;
    c_in_wb_sel = WB_MEM;
    c_in_funct3 = f3;
    c_in_offset = off;
    c_in_rd     = rd;
    c_mem_rdata = mem;
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; split_rvalid = 1'b0; in_wb_sel = 2'd0; in_funct3 = 3'd0;
    in_offset = 2'd0; in_rd = 5'd0; in_alu = 32'd0; in_pc4 = 32'd0; in_target = 32'd0;
    mem_rdata = 32'd0; split_rdata = 32'd0;
    c_in_valid = 1'b0; c_split_rvalid = 1'b0; c_in_wb_sel = 2'd0; c_in_funct3 = 3'd0;
    c_in_offset = 3'd0; c_in_rd = 5'd0; c_in_alu = 64'd0; c_in_pc4 = 64'd0;
    c_in_target = 64'd0; c_mem_rdata = 64'd0; c_split_rdata = 64'd0;

    step(); step();
    check("rst_in_ready", {63'd0, a_in_ready}, 64'd0);
    check("rst_wb_valid", {63'd0, a_wb_valid}, 64'd0);
    check("rst_split_req", {63'd0, a_split_req}, 64'd0);
    check("rst_wb_data", {32'd0, a_wb_data}, 64'd0);
    rst = 1'b0;
    step();
    check("ready_after_rst", {63'd0, a_in_ready}, 64'd1);

    // lb off=3 sign extension
    drive(WB_MEM, F3_LB, 2'd3, 5'd5, 32'h80FF_0000);
    step(); in_valid = 1'b0;
    check("lb_valid", {63'd0, a_wb_valid}, 64'd1);
    check("lb_data", {32'd0, a_wb_data}, 64'h0000_0000_FFFF_FF80);
    check("lb_we", {63'd0, a_wb_we}, 64'd1);
    check("lb_rd", {59'd0, a_wb_rd}, 64'd5);
    check("lb_b_data", {32'd0, b_wb_data}, 64'h0000_0000_FFFF_FF80);
    step();
    check("lb_pulse", {63'd0, a_wb_valid}, 64'd0);

    // lw off=2 straddle: A splits, B flags misalign
    drive(WB_MEM, F3_LW, 2'd2, 5'd7, 32'hDDCC_BBAA);
    step(); in_valid = 1'b0;
    check("lw_split_req", {63'd0, a_split_req}, 64'd1);
    check("lw_in_ready", {63'd0, a_in_ready}, 64'd0);
    check("lw_no_wb_yet", {63'd0, a_wb_valid}, 64'd0);
    check("lw_b_exc", {63'd0, b_misalign_exc}, 64'd1);
    check("lw_b_valid", {63'd0, b_wb_valid}, 64'd1);
    check("lw_b_we", {63'd0, b_wb_we}, 64'd0);
    step();
    check("lw_wait_req", {63'd0, a_split_req}, 64'd1);
    check("lw_wait_ready", {63'd0, a_in_ready}, 64'd0);
    check("lw_b_pulse", {63'd0, b_wb_valid}, 64'd0);
    split_rvalid = 1'b1; split_rdata = 32'h2211_FFEE;
    step(); split_rvalid = 1'b0;
    check("lw_split_valid", {63'd0, a_wb_valid}, 64'd1);
    check("lw_split_data", {32'd0, a_wb_data}, 64'h0000_0000_FFEE_DDCC);
    check("lw_split_rd", {59'd0, a_wb_rd}, 64'd7);
    check("lw_split_we", {63'd0, a_wb_we}, 64'd1);
    check("lw_split_req_low", {63'd0, a_split_req}, 64'd0);
    check("lw_ready_back", {63'd0, a_in_ready}, 64'd1);
    check("b_ignores_rvalid", {63'd0, b_wb_valid}, 64'd0);

    // lhu off=3 straddle: B misalign, A immediate second beat
    drive(WB_MEM, F3_LHU, 2'd3, 5'd9, 32'h1122_3344);
    step(); in_valid = 1'b0;
    check("lhu_b_valid", {63'd0, b_wb_valid}, 64'd1);
    check("lhu_b_exc", {63'd0, b_misalign_exc}, 64'd1);
    check("lhu_b_we", {63'd0, b_wb_we}, 64'd0);
    check("lhu_b_data", {32'd0, b_wb_data}, 64'd0);
    split_rvalid = 1'b1; split_rdata = 32'h5566_7788;
    step(); split_rvalid = 1'b0;
    check("lhu_a_data", {32'd0, a_wb_data}, 64'h0000_0000_0000_8811);
    check("lhu_a_exc", {63'd0, a_misalign_exc}, 64'd0);

    // PC+4 to x0
    in_pc4 = 32'h0000_0104;
    drive(WB_PC4, F3_LW, 2'd3, 5'd0, 32'h0);
    step(); in_valid = 1'b0;
    check("pc4_valid", {63'd0, a_wb_valid}, 64'd1);
    check("pc4_data", {32'd0, a_wb_data}, 64'h0000_0000_0000_0104);
    check("pc4_we_x0", {63'd0, a_wb_we}, 64'd0);

    // ALU ignores funct3/offset, no misalign on B
    in_alu = 32'hDEAD_BEEF;
    drive(WB_ALU, F3_LW, 2'd3, 5'd1, 32'h0);
    step(); in_valid = 1'b0;
    check("alu_data", {32'd0, a_wb_data}, 64'h0000_0000_DEAD_BEEF);
    check("alu_we", {63'd0, a_wb_we}, 64'd1);
    check("alu_b_exc", {63'd0, b_misalign_exc}, 64'd0);
    check("alu_no_split", {63'd0, a_split_req}, 64'd0);

    // back-to-back: target then lh
    in_target = 32'h0000_1000;
    drive(WB_TGT, F3_LB, 2'd0, 5'd2, 32'h0);
    step();
    check("b2b_tgt_data", {32'd0, a_wb_data}, 64'h0000_0000_0000_1000);
    drive(WB_MEM, F3_LH, 2'd2, 5'd3, 32'h8000_1234);
    step(); in_valid = 1'b0;
    check("b2b_lh_valid", {63'd0, a_wb_valid}, 64'd1);
    check("b2b_lh_data", {32'd0, a_wb_data}, 64'h0000_0000_FFFF_8000);
    check("b2b_lh_rd", {59'd0, a_wb_rd}, 64'd3);

    // ld on XLEN=32 is invalid: zero, no write, no exception, no split
    drive(WB_MEM, F3_LD, 2'd1, 5'd4, 32'hFFFF_FFFF);
    step(); in_valid = 1'b0;
    check("ld32_valid", {63'd0, a_wb_valid}, 64'd1);
    check("ld32_data", {32'd0, a_wb_data}, 64'd0);
    check("ld32_we", {63'd0, a_wb_we}, 64'd0);
    check("ld32_exc", {63'd0, b_misalign_exc}, 64'd0);
    check("ld32_ready", {63'd0, a_in_ready}, 64'd1);

    // reset while in SPLIT
    drive(WB_MEM, F3_LW, 2'd1, 5'd6, 32'h1234_5678);
    step(); in_valid = 1'b0;
    check("rs_split_req", {63'd0, a_split_req}, 64'd1);
    rst = 1'b1;
    step();
    check("rs_req_drop", {63'd0, a_split_req}, 64'd0);
    check("rs_no_wb", {63'd0, a_wb_valid}, 64'd0);
    rst = 1'b0; split_rvalid = 1'b1; split_rdata = 32'hAAAA_AAAA;
    step(); split_rvalid = 1'b0;
    check("rs_ready_back", {63'd0, a_in_ready}, 64'd1);
    check("rs_still_no_wb", {63'd0, a_wb_valid}, 64'd0);

    // XLEN=64 unit
    drive64(F3_LWU, 3'd4, 5'd10, 64'h8765_4321_0BAD_F00D);
    step(); c_in_valid = 1'b0;
    check("c_lwu_data", c_wb_data, 64'h0000_0000_8765_4321);
    check("c_lwu_we", {63'd0, c_wb_we}, 64'd1);
    drive64(F3_LW, 3'd4, 5'd11, 64'hF000_0001_0000_0000);
    step(); c_in_valid = 1'b0;
    check("c_lw_sext", c_wb_data, 64'hFFFF_FFFF_F000_0001);
    drive64(F3_LD, 3'd0, 5'd12, 64'h8000_0000_0000_0042);
    step(); c_in_valid = 1'b0;
    check("c_ld_data", c_wb_data, 64'h8000_0000_0000_0042);
    check("c_ld_no_split", {63'd0, c_split_req}, 64'd0);
    drive64(F3_LD, 3'd4, 5'd13, 64'h8877_6655_4433_2211);
    step(); c_in_valid = 1'b0;
    check("c_ld_split_req", {63'd0, c_split_req}, 64'd1);
    c_split_rvalid = 1'b1; c_split_rdata = 64'h0000_0000_CCBB_AA99;
    step(); c_split_rvalid = 1'b0;
    check("c_ld_split_valid", {63'd0, c_wb_valid}, 64'd1);
    check("c_ld_split_data", c_wb_data, 64'hCCBB_AA99_8877_6655);

    step();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
